// File: rtl/triple_rep_tx_pkg.sv
// triple_rep_tx_pkg: shared state encoding, repetition count and line levels for the triple-repetition transmitter
package triple_rep_tx_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
  localparam int REP_COUNT = 3;
  localparam int REP_W = $clog2(REP_COUNT);
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
endpackage

// File: rtl/triple_rep_tx_rep_cnt.sv
// triple_rep_tx_rep_cnt: mod-N repetition counter with enable and sync clear
//   clk, rst_n : clock, async active-low reset
//   en_i       : advance the count this cycle
//   clr_i      : force count to 0 (wins over en_i)
//   cnt_o      : current count 0..N-1
//   last_o     : count == N-1
module triple_rep_tx_rep_cnt
  import triple_rep_tx_pkg::*;
#(
  parameter int N = REP_COUNT,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_o  = cnt_q;
  assign last_o = cnt_q == W'(N - 1);
  always_comb cnt_d = clr_i ? '0 : en_i ? (last_o ? '0 : cnt_q + 1'b1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/triple_rep_tx.sv
// triple_rep_tx: frames a parallel word (start, data LSB-first, optional even parity, stop) and sends each symbol 3 times
//   clk, rst_n   : clock, async active-low reset
//   in_val_i     : in_data_i valid
//   in_rdy_o     : word accepted this cycle if in_val_i is high (IDLE or last STOP cycle)
//   in_data_i    : word to transmit
//   tx_line_o    : serial line, idles high
//   busy_o       : frame in progress
//   frame_done_o : pulse on the last cycle of the stop symbol
module triple_rep_tx
  import triple_rep_tx_pkg::*;
#(
  parameter int NBITS     = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_val_i,
  output logic             in_rdy_o,
  input  logic [NBITS-1:0] in_data_i,
  output logic             tx_line_o,
  output logic             busy_o,
  output logic             frame_done_o
);
  localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;
  state_e           state_q, state_d;
  logic [NBITS-1:0] sh_q, sh_d;
  logic             par_q, par_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [REP_W-1:0] rep_cnt;
  logic             rep_last, stop_last, last_bit, xfer;
  triple_rep_tx_rep_cnt #(.N(REP_COUNT)) u_rep (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (busy_o),
    .clr_i  (!busy_o),
    .cnt_o  (rep_cnt),
    .last_o (rep_last)
  );
  assign stop_last    = state_q == S_STOP && rep_cnt == REP_W'(REP_COUNT - 1);
  assign last_bit     = bit_q == BW'(NBITS - 1);
  assign busy_o       = state_q != S_IDLE;
  assign in_rdy_o     = state_q == S_IDLE || stop_last;
  assign frame_done_o = stop_last;
  assign xfer         = in_val_i && in_rdy_o;
  assign tx_line_o    = state_q == S_START  ? START_LVL :
                        state_q == S_DATA   ? sh_q[0]   :
                        state_q == S_PARITY ? par_q     : LINE_IDLE;
  always_comb begin
    state_d = state_q;
    sh_d    = xfer ? in_data_i : sh_q;
    par_d   = xfer ? ^in_data_i : par_q;
    bit_d   = bit_q;
    case (state_q)
      S_IDLE:   if (xfer) state_d = S_START;
      S_START:  if (rep_last) state_d = S_DATA;
      S_DATA:   if (rep_last) begin
        sh_d  = sh_q >> 1;
        bit_d = last_bit ? '0 : bit_q + 1'b1;
        if (last_bit) state_d = PARITY_EN ? S_PARITY : S_STOP;
      end
      S_PARITY: if (rep_last) state_d = S_STOP;
      S_STOP:   if (rep_last) state_d = xfer ? S_START : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      par_q   <= 1'b0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      bit_q   <= bit_d;
    end
endmodule
